soc_system_pio_poller: RTL and testbench

//  Avalon-MM master that sequences an edge-capture input PIO (dip-switch/button PIO class) without HPS help.

---
 rtl/soc_system_pio_pkg.sv | 17 +
 rtl/soc_system_poll_timer.sv | 29 ++
 rtl/soc_system_pio_poller.sv | 136 +++++++++++++
 tb/tb_soc_system_pio_poller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register offsets and FSM state encoding for the PIO edge-capture poller.
package soc_system_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WAIT_EDGE,
        CLR,
        RD_DATA,
        WAIT_DATA,
        EMIT
    } poller_state_t;

endpackage

// File: rtl/soc_system_poll_timer.sv
// Poll interval countdown: load wins, counts down while enabled, parks at zero.
module soc_system_poll_timer #(
    parameter int POLL_CYCLES = 50000,
    parameter int CNT_W       = $clog2(POLL_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= RELOAD;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/soc_system_pio_poller.sv
// Avalon-MM master that polls a PIO edge-capture register, clears the bits it saw,
// reads the live data and posts {mask,data} on a valid/ready stream.
module soc_system_pio_poller
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int POLL_CYCLES = 50000,
    parameter int CNT_W       = $clog2(POLL_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_mask,
    output logic [WIDTH-1:0] ev_data,
    output logic             busy
);

    poller_state_t    r_state;
    logic [1:0]       r_addr;
    logic             r_cs;
    logic             r_wr_n;
    logic [31:0]      r_wd;
    logic             r_valid;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    logic             w_tzero;
    logic             w_start;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused_rd;

    assign w_rd        = avm_readdata[WIDTH-1:0];
    // readdata bits above WIDTH carry nothing for this PIO and are dropped
    assign w_unused_rd = ^avm_readdata;
    assign w_start     = (r_state == IDLE) && w_tzero && enable;

    soc_system_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_start),
        .i_en   ((r_state == IDLE) && enable),
        .o_zero (w_tzero)
    );

    // Bus/stream outputs are written on the transition into the state that owns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= PIO_ADDR_DATA;
            r_cs    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_wd    <= '0;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RD_EDGE;
                        r_addr  <= PIO_ADDR_EDGE;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                RD_EDGE: begin
                    r_state <= WAIT_EDGE;
                    r_cs    <= 1'b0;
                end
                WAIT_EDGE: begin
                    r_mask <= w_rd;
                    if (w_rd == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= CLR;
                        r_cs    <= 1'b1;
                        r_wr_n  <= 1'b0;
                        r_wd    <= 32'(w_rd);
                    end
                end
                CLR: begin
                    r_state <= RD_DATA;
                    r_addr  <= PIO_ADDR_DATA;
                    r_wr_n  <= 1'b1;
                    r_wd    <= '0;
                end
                RD_DATA: begin
                    r_state <= WAIT_DATA;
                    r_cs    <= 1'b0;
                end
                WAIT_DATA: begin
                    r_data  <= w_rd;
                    r_state <= EMIT;
                    r_valid <= 1'b1;
                end
                EMIT: begin
                    if (ev_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b0;
                    r_wr_n  <= 1'b1;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_wr_n;
    assign avm_writedata  = r_wd;
    assign ev_valid       = r_valid;
    assign ev_mask        = r_mask;
    assign ev_data        = r_data;
    assign busy           = r_busy;

endmodule

// File: tb/tb_soc_system_pio_poller.sv
// Poller paired with an edge-capture PIO model (registered readdata, clear priority).
module tb_soc_system_pio_poller;

    localparam int W  = 4;
    localparam int PC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          ev_ready = 1'b1;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata = 32'hA5A5_A5A0;
    logic          ev_valid;
    logic [W-1:0]  ev_mask;
    logic [W-1:0]  ev_data;
    logic          busy;

    logic [W-1:0]  in_port = '0;
    logic [W-1:0]  pio_in = '0;
    logic [W-1:0]  pio_edge = '0;

    int n_tot = 0, n_bad = 0;
    int n_rd = 0, n_wr = 0, n_ev = 0, n_bus = 0, cyc = 0;
    logic [W-1:0]   exp_wr[$];
    logic [2*W-1:0] exp_ev[$];

    soc_system_pio_poller #(.WIDTH(W), .POLL_CYCLES(PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_mask        (ev_mask),
        .ev_data        (ev_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO model: any-edge capture, clear wins over a same-cycle edge, upper readdata bits junk
    always @(posedge clk) begin
        pio_in   <= in_port;
        pio_edge <= (pio_edge | (in_port ^ pio_in)) &
                    ~((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata[W-1:0] : '0);
        if (avm_chipselect && avm_write_n)
            avm_readdata <= {28'hA5A5A5A, (avm_address == 2'd3) ? pio_edge :
                                          (avm_address == 2'd0) ? pio_in : 4'h0};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect) n_bus++;
            if (avm_chipselect && avm_write_n && avm_address == 2'd3) n_rd++;
            if (avm_chipselect && !avm_write_n) begin
                n_wr++;
                chk("wr_addr", avm_address, 3);
                chk("wr_hi", avm_writedata[31:W], 0);
                chk("wr_q", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("wr_data", avm_writedata[W-1:0], exp_wr.pop_front());
            end
            if (ev_valid && ev_ready) begin
                n_ev++;
                chk("ev_q", exp_ev.size() != 0, 1);
                if (exp_ev.size() != 0) chk("ev", {ev_mask, ev_data}, exp_ev.pop_front());
            end
        end
    end

    task automatic wait_ev(input int n, input string tag);
        int k = 0;
        while (n_ev < n && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, n_ev, n);
    endtask

    // kind: 0=RD_EDGE 1=CLR 2=RD_DATA 3=ev_valid; returns at the negedge it was seen
    task automatic wait_cond(input int kind, input string tag);
        int  k = 0;
        bit  hit = 0;
        while (!hit && k < 400) begin
            @(negedge clk);
            k++;
            case (kind)
                0: hit = avm_chipselect && avm_write_n && avm_address == 2'd3;
                1: hit = avm_chipselect && !avm_write_n;
                2: hit = avm_chipselect && avm_write_n && avm_address == 2'd0;
                default: hit = ev_valid;
            endcase
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", avm_address, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_wr_n", avm_write_n, 1);
        chk("rst_wd", avm_writedata, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_mask", ev_mask, 0);
        chk("rst_data", ev_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;

        // 1: idle polling, one edge read every PC+2 cycles, never a write
        repeat (10) @(posedge clk);
        #1 n_rd = 0;
        repeat (60) @(posedge clk);
        #1;
        chk("t1_reads", n_rd, 60 / (PC + 2));
        chk("t1_writes", n_wr, 0);
        chk("t1_events", n_ev, 0);

        // 2: two rising bits reported and cleared
        exp_wr.push_back(4'h5);
        exp_ev.push_back({4'b0101, 4'b0101});
        in_port = 4'b0101;
        wait_ev(1, "t2_tmo");
        chk("t2_edge_clr", pio_edge, 0);

        // 3: stalled consumer blocks the bus; edge during stall reported next
        @(posedge clk); #1;
        ev_ready = 1'b0;
        exp_wr.push_back(4'h1);
        exp_ev.push_back({4'b0001, 4'b0100});
        in_port = 4'b0100;
        wait_cond(3, "t3_valid_tmo");
        n_bus = 0;
        in_port = 4'b1100;
        repeat (100) @(posedge clk);
        #1;
        chk("t3_quiet", n_bus, 0);
        chk("t3_hold_valid", ev_valid, 1);
        chk("t3_hold_mask", ev_mask, 4'b0001);
        chk("t3_busy", busy, 1);
        exp_wr.push_back(4'h8);
        exp_ev.push_back({4'b1000, 4'b1100});
        ev_ready = 1'b1;
        wait_ev(3, "t3_tmo");

        // 4: edge landing after the edge read is preserved, not cleared
        @(posedge clk); #1;
        exp_wr.push_back(4'h1);
        exp_ev.push_back({4'b0001, 4'b1111});
        exp_wr.push_back(4'h2);
        exp_ev.push_back({4'b0010, 4'b1111});
        in_port = 4'b1101;
        @(posedge clk); #1;
        wait_cond(0, "t4_rd_tmo");
        in_port = 4'b1111;
        wait_ev(5, "t4_tmo");

        // 5: enable dropped mid-sequence, event still emitted, timer held afterwards
        @(posedge clk); #1;
        exp_wr.push_back(4'h4);
        exp_ev.push_back({4'b0100, 4'b1011});
        in_port = 4'b1011;
        @(posedge clk); #1;
        wait_cond(2, "t5_rdd_tmo");
        @(posedge clk); #1;
        enable = 1'b0;
        wait_ev(6, "t5_tmo");
        n_bus = 0;
        repeat (1000) @(posedge clk);
        #1;
        chk("t5_quiet", n_bus, 0);
        chk("t5_busy", busy, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        t0 = cyc;
        wait_cond(0, "t5_resume_tmo");
        chk("t5_resume", cyc - t0, PC);

        // 6: reset during the clear write; uncleared bit re-reported afterwards
        @(posedge clk); #1;
        exp_wr.push_back(4'h1);
        in_port = 4'b1010;
        wait_cond(1, "t6_clr_tmo");
        #2 reset = 1'b1;
        #1;
        chk("t6_wr_n", avm_write_n, 1);
        chk("t6_cs", avm_chipselect, 0);
        chk("t6_wd", avm_writedata, 0);
        chk("t6_addr", avm_address, 0);
        chk("t6_mask", ev_mask, 0);
        chk("t6_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_wr.push_back(4'h1);
        exp_ev.push_back({4'b0001, 4'b1010});
        wait_ev(7, "t6_tmo");

        repeat (20) @(posedge clk);
        #1;
        chk("end_edge", pio_edge, 0);
        chk("end_wr_q", exp_wr.size(), 0);
        chk("end_ev_q", exp_ev.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
